spoofer_checker: RTL
====================

Name: spoofer_checker

Overview:
- Avalon-ST sink that consumes the incrementing count stream produced by the spoofer source core.
- Verifies that each accepted word equals the previous word + 1, wrapping at MAX_NUM, with the upper ZEROS_WIDTH bits zero.
- Counts accepted beats and sequence errors, and records the first failing pair.
- Sits at the far end of FPGA bench pipelines to prove a stream path is lossless and in order.

Parameters:
- WIDTH, 24: significant count bits in each word.
- MAX_NUM, (1 << WIDTH) - 1: last count value before wrap to 0.
- ZEROS_WIDTH, 32 - WIDTH: upper word bits that must be zero.
- STOP_ON_ERROR, 0: 1 = enter FAULT on first error and hold snk_ready low until clear.

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous; clears counters and returns to SYNC.
- snk_data  input  WIDTH+ZEROS_WIDTH  stream word.
- snk_valid  input  1  source has a word.
- snk_ready  output  1  checker can accept; registered.
- locked  output  1  in CHECK state.
- beat_count  output  32  accepted beats, wraps at 2^32.
- error_count  output  16  sequence/format errors, saturates at 16'hFFFF.
- error_pulse  output  1  one-cycle pulse per error.
- first_expected  output  WIDTH+ZEROS_WIDTH  expected word at the first error.
- first_received  output  WIDTH+ZEROS_WIDTH  received word at the first error.
- fault  output  1  in FAULT state.

Behaviour:
- Transfer: a beat is accepted on the rising edge where snk_valid && snk_ready. Nothing else consumes data.
- Reset state: rst forces all outputs to 0, including snk_ready, and enters SYNC. snk_ready rises the cycle after rst deasserts.
- Reset mid-operation behaves identically and discards any in-flight beat.
- State SYNC:
  - The first accepted beat sets expected = next(data) and increments beat_count.
  - No error is checked on this beat unless the upper bits are nonzero.
  - Then go to CHECK.
- State CHECK:
  - Each accepted beat is compared with expected.
  - On a match: expected = next(data), beat_count + 1.
  - On a mismatch, or nonzero bits in [WIDTH+ZEROS_WIDTH-1 : WIDTH]:
    - error_count + 1 (saturating), error_pulse = 1 the next cycle.
    - If this is the first error since reset/clear, capture first_expected and first_received.
    - Resync with expected = next(data), so a single dropped word counts as exactly one error.
    - If STOP_ON_ERROR = 1, go to FAULT.
- State FAULT: snk_ready = 0, fault = 1, counters frozen. Only clear or rst leaves FAULT (to SYNC).
- next(x): if x[WIDTH-1:0] == MAX_NUM then 0, else x[WIDTH-1:0] + 1. Upper bits of expected are always 0.
- Latency: all status outputs are registered and update the cycle after the accepting edge.
- Clear:
  - Zeroes beat_count, error_count, first_* and the first-error flag.
  - Enters SYNC next cycle; snk_ready stays high through clear, except in FAULT.
  - A beat accepted in the same cycle as clear is discarded: not counted, not checked.
  - A beat and rst in the same cycle: rst wins.
- Counter boundaries:
  - beat_count wraps from 32'hFFFF_FFFF to 0.
  - error_count sticks at 16'hFFFF; error_pulse still fires.
- Idle: snk_valid low for any number of cycles has no effect on state or counters.

Optional Feature:
- Macro: SPOOFER_CHECKER_BACKPRESSURE_EN.
- Defined:
  - Adds a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on rst or clear), stepped every cycle.
  - snk_ready is driven low whenever lfsr[1:0] == 2'b00, giving about 25% backpressure to stress the source hold rules.
  - Checking logic is unchanged.
- Undefined: no LFSR; snk_ready = 1 in SYNC and CHECK.

Test Plan:
- Wrap with WIDTH=4: stream 14,15,0,1,2 -> beat_count=5, error_count=0, locked=1.
- Dropped word: 3,4,6,7 -> error_count=1, first_expected=5, first_received=6, one error_pulse; then 8 gives no new error.
- Upper bits with WIDTH=24: 0x0000_0010 then 0x0100_0011 -> error_count=1; next 0x0000_0012 gives no error.
- STOP_ON_ERROR=1: 0,1,3 -> fault=1, snk_ready=0, beat_count=3. Pulse clear -> fault=0, snk_ready=1, counters=0; 9,10 give beat_count=2.
- Reset and clear mid-stream: rst during a valid beat of value 5 -> counters 0. Then 7,8 -> SYNC accepts 7, error_count=0. clear coincident with beat 9 -> beat 9 not counted.
- Backpressure with macro defined: 1000 consecutive counts from a compliant source -> beat_count=1000, error_count=0, snk_ready observed low at least once.

Source files
------------

// File: rtl/spoofer_checker.sv
// Avalon-ST sink that verifies an incrementing count stream (wrap at MAX_NUM, zero upper bits).
// Define SPOOFER_CHECKER_BACKPRESSURE_EN to add LFSR-driven pseudo-random backpressure on snk_ready.
module spoofer_checker #(
    parameter int               WIDTH         = 24,
    parameter logic [WIDTH-1:0] MAX_NUM       = {WIDTH{1'b1}},
    parameter int               ZEROS_WIDTH   = 32 - WIDTH,
    parameter bit               STOP_ON_ERROR = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic [WIDTH+ZEROS_WIDTH-1:0] snk_data,
    input  logic                         snk_valid,
    output logic                         snk_ready,
    output logic                         locked,
    output logic [31:0]                  beat_count,
    output logic [15:0]                  error_count,
    output logic                         error_pulse,
    output logic [WIDTH+ZEROS_WIDTH-1:0] first_expected,
    output logic [WIDTH+ZEROS_WIDTH-1:0] first_received,
    output logic                         fault
);
    localparam int DW = WIDTH + ZEROS_WIDTH;

    typedef enum logic [1:0] {SYNC, CHECK, FAULT} state_t;

    state_t        state;
    logic [DW-1:0] expected;
    logic          err_seen;
    logic          accept, upper_bad, mismatch, err_now, go_fault;
    logic          bp_next, bp_seed;
    logic [DW-1:0] nxt;

    function automatic logic [DW-1:0] next_word(input logic [DW-1:0] x);
        logic [DW-1:0] r;
        r = '0;
        r[WIDTH-1:0] = (x[WIDTH-1:0] == MAX_NUM) ? '0 : WIDTH'(x[WIDTH-1:0] + 1'b1);
        return r;
    endfunction

    // A beat coinciding with clear is dropped entirely.
    assign accept    = snk_valid && snk_ready && !clear;
    assign upper_bad = (snk_data >> WIDTH) != '0;
    assign mismatch  = snk_data != expected;
    assign err_now   = accept && ((state == CHECK) ? mismatch : upper_bad);
    assign go_fault  = STOP_ON_ERROR && err_now;
    assign nxt       = next_word(snk_data);

`ifdef SPOOFER_CHECKER_BACKPRESSURE_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    logic [15:0] lfsr, lfsr_step;

    assign lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    // ready is registered alongside the LFSR, so it tracks the LFSR value it will sit next to
    assign bp_next   = lfsr_step[1:0] != 2'b00;
    assign bp_seed   = LFSR_SEED[1:0] != 2'b00;

    always_ff @(posedge clk) begin
        if (rst || clear) lfsr <= LFSR_SEED;
        else              lfsr <= lfsr_step;
    end
`else
    assign bp_next = 1'b1;
    assign bp_seed = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= SYNC;
            expected       <= '0;
            err_seen       <= 1'b0;
            snk_ready      <= 1'b0;
            locked         <= 1'b0;
            beat_count     <= '0;
            error_count    <= '0;
            error_pulse    <= 1'b0;
            first_expected <= '0;
            first_received <= '0;
            fault          <= 1'b0;
        end else if (clear) begin
            state          <= SYNC;
            expected       <= '0;
            err_seen       <= 1'b0;
            snk_ready      <= bp_seed;
            locked         <= 1'b0;
            beat_count     <= '0;
            error_count    <= '0;
            error_pulse    <= 1'b0;
            first_expected <= '0;
            first_received <= '0;
            fault          <= 1'b0;
        end else begin
            error_pulse <= err_now;
            snk_ready   <= !(state == FAULT || go_fault) && bp_next;
            if (accept) begin
                beat_count <= beat_count + 32'd1;
                // Always resync on the received word so one drop costs exactly one error.
                expected   <= nxt;
                if (err_now) begin
                    if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
                    if (!err_seen) begin
                        err_seen       <= 1'b1;
                        first_expected <= expected;
                        first_received <= snk_data;
                    end
                end
                state  <= go_fault ? FAULT : CHECK;
                locked <= !go_fault;
                fault  <= go_fault;
            end
        end
    end

endmodule
